// File: rtl/pps_pulse_monitor.sv
// Measures phase, high width and PPS period of a divided-PPS pulse against a
// PPS reference. Both inputs are resynchronised into the 10 MHz domain.
module pps_pulse_monitor #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLKS_PER_US = 10,
    parameter int TIMEOUT_PPS = 8
) (
    input  logic                      i_clk_10,
    input  logic                      i_rst,
    input  logic                      i_pps_raw,
    input  logic                      i_pulse,
    input  logic [DATA_WIDTH-1:0]     i_start,
    input  logic [DATA_WIDTH-1:0]     i_stop,
    output logic [3*DATA_WIDTH-1:0]   o_phase_us,
    output logic [DATA_WIDTH-1:0]     o_width_us,
    output logic [DATA_WIDTH-1:0]     o_period_pps,
    output logic                      o_valid,
    output logic                      o_period_valid,
    output logic                      o_timeout,
    output logic                      o_overflow,
    output logic                      o_busy
);
    localparam int PW = 3*DATA_WIDTH;
    localparam int TW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [TW-1:0]         TICK_LAST = TW'(CLKS_PER_US - 1);
    localparam logic [DATA_WIDTH-1:0] TO_CNT    = DATA_WIDTH'(TIMEOUT_PPS);

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_RISE, HIGH} state_t;
    state_t r_state, w_next;

    logic [1:0]            r_pps_sr, r_pul_sr, r_sync_cnt;
    logic                  w_start, w_stop, w_en, w_ok;
    logic                  w_pps_rise, w_pul_rise, w_pul_fall;
    logic                  w_act, w_arm, w_rise_cap, w_fall_cap;
    logic [TW-1:0]         r_tick, r_wtick, w_tick_nxt, w_wtick_nxt;
    logic [PW-1:0]         r_us, r_phase, w_us_nxt, w_phase_cap;
    logic [DATA_WIDTH-1:0] r_wus, r_ppscnt, w_wus_nxt, w_per_close;
    logic                  r_first_done;

    assign w_start = (i_start != '0);
    assign w_stop  = (i_stop != '0);
    assign w_en    = w_start && !w_stop;

    // Edges are only trusted once both flops hold real samples, so a level
    // already present at enable is never mistaken for a fresh edge.
    always_ff @(posedge i_clk_10) begin
        if (i_rst || !w_en) begin
            r_pps_sr   <= 2'b00;
            r_pul_sr   <= 2'b00;
            r_sync_cnt <= 2'd0;
        end else begin
            r_pps_sr <= {r_pps_sr[0], i_pps_raw};
            r_pul_sr <= {r_pul_sr[0], i_pulse};
            if (r_sync_cnt != 2'd2)
                r_sync_cnt <= r_sync_cnt + 2'd1;
        end
    end

    assign w_ok       = (r_sync_cnt == 2'd2);
    assign w_pps_rise = w_ok && (r_pps_sr == 2'b01);
    assign w_pul_rise = w_ok && (r_pul_sr == 2'b01);
    assign w_pul_fall = w_ok && (r_pul_sr == 2'b10);

    always_ff @(posedge i_clk_10) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_en)       w_next = ARMED;
            ARMED:     if (w_pps_rise) w_next = WAIT_RISE;
            WAIT_RISE: if (w_pul_rise) w_next = HIGH;
            HIGH:      if (w_pul_fall) w_next = WAIT_RISE;
            default:                   w_next = IDLE;
        endcase
        if (w_stop)
            w_next = IDLE;
    end

    assign w_act      = (r_state != IDLE) && !w_stop;
    assign w_arm      = (r_state == IDLE) && w_en;
    assign w_rise_cap = w_act && (r_state == WAIT_RISE) && w_pul_rise;
    assign w_fall_cap = w_act && (r_state == HIGH) && w_pul_fall;
    assign o_busy     = (r_state != IDLE);

    // The rise cycle itself counts as elapsed cycle 0, so after k cycles the
    // counters read floor(k / CLKS_PER_US).
    always_comb begin
        w_tick_nxt = w_pps_rise ? '0 : r_tick;
        w_us_nxt   = w_pps_rise ? '0 : r_us;
        if (w_tick_nxt == TICK_LAST) begin
            w_tick_nxt = '0;
            if (w_us_nxt != '1)
                w_us_nxt = w_us_nxt + PW'(1);
        end else begin
            w_tick_nxt = w_tick_nxt + TW'(1);
        end

        w_wtick_nxt = w_pul_rise ? '0 : r_wtick;
        w_wus_nxt   = w_pul_rise ? '0 : r_wus;
        if (w_wtick_nxt == TICK_LAST) begin
            w_wtick_nxt = '0;
            if (w_wus_nxt != '1)
                w_wus_nxt = w_wus_nxt + DATA_WIDTH'(1);
        end else begin
            w_wtick_nxt = w_wtick_nxt + TW'(1);
        end

        w_phase_cap = w_pps_rise ? '0 : r_us;
        w_per_close = (w_pps_rise && r_ppscnt != '1) ? r_ppscnt + DATA_WIDTH'(1) : r_ppscnt;
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            r_tick         <= '0;
            r_us           <= '0;
            r_wtick        <= '0;
            r_wus          <= '0;
            r_ppscnt       <= '0;
            r_phase        <= '0;
            r_first_done   <= 1'b0;
            o_phase_us     <= '0;
            o_width_us     <= '0;
            o_period_pps   <= '0;
            o_valid        <= 1'b0;
            o_period_valid <= 1'b0;
            o_timeout      <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (w_arm) begin
                r_tick       <= '0;
                r_us         <= '0;
                r_wtick      <= '0;
                r_wus        <= '0;
                r_ppscnt     <= '0;
                r_first_done <= 1'b0;
                o_timeout    <= 1'b0;
                o_overflow   <= 1'b0;
            end else if (w_act) begin
                r_tick  <= w_tick_nxt;
                r_us    <= w_us_nxt;
                r_wtick <= w_wtick_nxt;
                r_wus   <= w_wus_nxt;

                if (w_rise_cap)
                    r_ppscnt <= '0;
                else if (w_pps_rise && r_ppscnt != '1)
                    r_ppscnt <= r_ppscnt + DATA_WIDTH'(1);

                if (w_rise_cap) begin
                    r_phase      <= w_phase_cap;
                    r_first_done <= 1'b1;
                    if (r_first_done) begin
                        o_period_pps   <= w_per_close;
                        o_period_valid <= 1'b1;
                    end
                    if (w_phase_cap == '1)
                        o_overflow <= 1'b1;
                end

                if (r_state == HIGH && r_wus == '1)
                    o_overflow <= 1'b1;

                if ((r_state == ARMED || r_state == WAIT_RISE) && r_ppscnt >= TO_CNT)
                    o_timeout <= 1'b1;

                if (w_fall_cap) begin
                    o_valid    <= 1'b1;
                    o_phase_us <= r_phase;
                    o_width_us <= r_wus;
                end
            end
        end
    end
endmodule

// File: tb/tb_pps_pulse_monitor.sv
// Bench for pps_pulse_monitor: directed sequence with randomised gaps and
// widths, expectations derived from cycle timestamps of the driven events.
module tb_pps_pulse_monitor;
    localparam int DW   = 8;
    localparam int CPU  = 10;
    localparam int TO   = 8;
    localparam int WMAX = (1 << DW) - 1;

    logic              clk = 1'b0;
    logic              rst, pps, pulse;
    logic [DW-1:0]     start, stop;
    logic [3*DW-1:0]   phase;
    logic [DW-1:0]     width, period;
    logic              valid, pv, tmo, ovf, busy;

    int vectors = 0, miscompares = 0;
    int vcount = 0, exp_vcount = 0;
    int pps_left = 0, pps_since = 0, rises_since_arm = 0;
    int exp_period = 0, exp_phase = 0, exp_width = 0;
    bit exp_pv = 1'b0;

    always #50 clk = ~clk;

    pps_pulse_monitor #(.DATA_WIDTH(DW), .CLKS_PER_US(CPU), .TIMEOUT_PPS(TO)) dut (
        .i_clk_10(clk), .i_rst(rst), .i_pps_raw(pps), .i_pulse(pulse),
        .i_start(start), .i_stop(stop),
        .o_phase_us(phase), .o_width_us(width), .o_period_pps(period),
        .o_valid(valid), .o_period_valid(pv), .o_timeout(tmo),
        .o_overflow(ovf), .o_busy(busy)
    );

    always @(posedge clk) if (valid === 1'b1) vcount <= vcount + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (pps_left > 0) begin
                pps_left--;
                if (pps_left == 0) pps = 1'b0;
            end
        end
    endtask

    task automatic raise_pps();
        pps = 1'b1;
        pps_left = 5;
        pps_since++;
    endtask

    // A PPS rise in the same cycle as the pulse rise belongs to the closing period.
    task automatic rise_pulse();
        pulse = 1'b1;
        if (rises_since_arm > 0) begin
            exp_period = (pps_since > WMAX) ? WMAX : pps_since;
            exp_pv = 1'b1;
        end
        rises_since_arm++;
        pps_since = 0;
    endtask

    task automatic arm();
        stop = 8'h01;
        step(2);
        stop = '0;
        start = DW'($urandom_range(1, WMAX));
        pps_since = 0;
        rises_since_arm = 0;
        step(4);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_width"}, width, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_pvalid"}, pv, 0);
        chk({tag, "_timeout"}, tmo, 0);
        chk({tag, "_overflow"}, ovf, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // g = cycles from PPS rise to pulse rise, h = pulse high cycles.
    task automatic fall_check(input int g, input int h);
        pulse = 1'b0;
        exp_phase = g / CPU;
        exp_width = (h / CPU > WMAX) ? WMAX : h / CPU;
        exp_vcount++;
        step(2);
        chk("valid_strobe", valid, 1);
        chk("phase_us", phase, exp_phase);
        chk("width_us", width, exp_width);
        chk("period_valid", pv, exp_pv);
        chk("period_pps", period, exp_period);
        step(1);
        chk("valid_one_cycle", valid, 0);
        chk("valid_count", vcount, exp_vcount);
    endtask

    task automatic measure(input int g, input int h);
        raise_pps();
        step(g);
        rise_pulse();
        step(h);
        fall_check(g, h);
        step(6);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pps = 1'b0; pulse = 1'b0; start = '0; stop = '0;
        step(3);
        check_all_zero("reset");

        rst = 1'b0;
        arm();
        chk("armed_busy", busy, 1);
        chk("armed_valid", valid, 0);

        measure(50, 30);
        measure(25, 9);

        for (int i = 0; i < 6; i++) begin
            int k;
            k = $urandom_range(1, 3);
            for (int j = 1; j < k; j++) begin
                raise_pps();
                step(30);
            end
            measure($urandom_range(0, 300), $urandom_range(1, 400));
        end

        // Pulse coincident with every third PPS of a 1000-cycle PPS train.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        exp_pv = 1'b0;
        exp_period = 0;
        arm();
        for (int p = 0; p < 7; p++) begin
            raise_pps();
            if (p == 1 || p == 4) begin
                rise_pulse();
                step(20);
                fall_check(0, 20);
                step(1000 - 23);
            end else begin
                step(1000);
            end
        end

        chk("no_overflow_yet", ovf, 0);
        measure(10, 2600);
        chk("width_overflow", ovf, 1);

        arm();
        chk("arm_clears_overflow", ovf, 0);
        for (int p = 0; p < TO - 1; p++) begin
            raise_pps();
            step(100);
        end
        chk("timeout_before_limit", tmo, 0);
        raise_pps();
        step(10);
        chk("timeout_at_limit", tmo, 1);
        measure(40, 60);
        chk("timeout_sticky", tmo, 1);
        arm();
        chk("rearm_clears_timeout", tmo, 0);
        chk("rearm_busy", busy, 1);

        raise_pps();
        step(25);
        rise_pulse();
        step(15);
        stop = 8'h80;
        step(1);
        chk("stop_busy", busy, 0);
        chk("stop_valid", valid, 0);
        chk("stop_phase_held", phase, exp_phase);
        chk("stop_width_held", width, exp_width);
        chk("stop_pvalid_held", pv, exp_pv);
        chk("stop_period_held", period, exp_period);
        pulse = 1'b0;
        step(6);
        chk("stop_no_valid", vcount, exp_vcount);

        arm();
        raise_pps();
        step(33);
        rise_pulse();
        step(20);
        rst = 1'b1;
        step(1);
        check_all_zero("mid_high_reset");
        exp_pv = 1'b0;
        exp_period = 0;
        pulse = 1'b0;
        step(2);
        rst = 1'b0;
        step(10);
        chk("reset_no_valid", vcount, exp_vcount);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pps_pulse_monitor.md
PPS_PULSE_MONITOR -- requirements
Module: pps_pulse_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, base register width for all measurement fields.
REQ-002 SHALL have parameter CLKS_PER_US, default 10, i_clk_10 cycles per microsecond tick.
REQ-003 SHALL have parameter TIMEOUT_PPS, default 8, PPS edges without a pulse rise before timeout.
REQ-004 SHALL have port i_clk_10  input  1  10 MHz clock.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_pps_raw  input  1  asynchronous PPS reference.
REQ-007 SHALL have port i_pulse  input  1  asynchronous divided-PPS pulse under test.
REQ-008 SHALL have port i_start  input  DATA_WIDTH  nonzero = enable measurement.
REQ-009 SHALL have port i_stop  input  DATA_WIDTH  nonzero = abort and disable; overrides i_start.
REQ-010 SHALL have port o_phase_us  output  3*DATA_WIDTH  microseconds from PPS rise to pulse rise.
REQ-011 SHALL have port o_width_us  output  DATA_WIDTH  pulse high time in microseconds.
REQ-012 SHALL have port o_period_pps  output  DATA_WIDTH  PPS rising edges between consecutive pulse rises.
REQ-013 SHALL have port o_valid  output  1  one-cycle strobe: o_phase_us/o_width_us updated.
REQ-014 SHALL have port o_period_valid  output  1  level: o_period_pps holds a real measurement.
REQ-015 SHALL have port o_timeout  output  1  sticky: no pulse rise within TIMEOUT_PPS PPS edges.
REQ-016 SHALL have port o_overflow  output  1  sticky: phase or width counter saturated.
REQ-017 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL pass i_pps_raw and i_pulse through identical 2-flop shift registers; rise = 01, fall = 10; both registers held at 00 while i_rst, i_start==0 or i_stop!=0.
REQ-019 SHALL implement states IDLE, ARMED, WAIT_RISE, HIGH.
REQ-020 SHALL go IDLE->ARMED when i_start!=0 and i_stop==0; ARMED->WAIT_RISE on first PPS rise; WAIT_RISE->HIGH on pulse rise; HIGH->WAIT_RISE on pulse fall.
REQ-021 SHALL force IDLE on the next clock from any state when i_stop!=0; outputs other than o_valid and o_busy retain their values.
REQ-022 SHALL run a microsecond counter (3*DATA_WIDTH) plus 0..CLKS_PER_US-1 tick counter, both cleared on every PPS rise, counter incremented on each tick wrap, saturating at all-ones.
REQ-023 SHALL, on pulse rise in WAIT_RISE, latch phase = microsecond counter value (0 if PPS rise in the same cycle), i.e. floor(cycles since PPS rise / CLKS_PER_US).
REQ-024 SHALL count PPS rises in a DATA_WIDTH saturating counter cleared at entry to ARMED and at each pulse rise; a PPS rise coincident with a pulse rise counts toward the period being closed.
REQ-025 SHALL, on pulse rise, latch period = PPS-rise count; o_period_pps and o_period_valid update only at the second and later pulse rises since ARMED.
REQ-026 SHALL measure width in HIGH with its own tick counter cleared at pulse rise: width = floor(high cycles / CLKS_PER_US), saturating at all-ones.
REQ-027 SHALL, on pulse fall in HIGH, register o_phase_us and o_width_us and assert o_valid for exactly one cycle, the cycle after fall detection.
REQ-028 SHALL set o_overflow when phase or width saturates; held until next IDLE->ARMED transition or reset.
REQ-029 SHALL set o_timeout when PPS-rise count reaches TIMEOUT_PPS in ARMED or WAIT_RISE; stays in state; cleared like o_overflow.
REQ-030 SHALL ignore a pulse already high at arming until it falls and rises again (edge-based only).
REQ-031 SHALL never assert o_valid for a pulse whose rise preceded the current arming.

Reset
REQ-032 SHALL, while i_rst=1 at a clock edge, enter IDLE and zero all counters, shift registers and outputs (o_phase_us, o_width_us, o_period_pps, o_valid, o_period_valid, o_timeout, o_overflow, o_busy).
REQ-033 SHALL, with i_rst asserted mid-HIGH, produce no o_valid for the interrupted pulse.

Verification
REQ-034 SHALL pass: start=1, PPS rise, pulse rises 50 cycles later, high 30 cycles -> o_phase_us=5, o_width_us=3, o_valid one cycle, o_period_valid=0.
REQ-035 SHALL pass: PPS period 1000 cycles, pulse every 3rd PPS, phase 0 coincident rise, width 20 cycles -> o_phase_us=0, o_width_us=2, o_period_pps=3, o_period_valid=1 from second pulse.
REQ-036 SHALL pass: pulse high 9 cycles -> o_width_us=0, o_valid still strobes.
REQ-037 SHALL pass: armed, 8 PPS rises, no pulse -> o_timeout=1; later pulse still measured; stop then start clears o_timeout.
REQ-038 SHALL pass: i_stop asserted mid-HIGH -> IDLE next cycle, o_busy=0, no o_valid, previous outputs unchanged.
REQ-039 SHALL pass: i_rst mid-HIGH -> all outputs 0 next cycle, no o_valid.
